// File: rtl/truth_table_checker.sv
// Truth-table sweeper: on start, drives all 2^N input vectors in ascending order onto an
// external combinational block, samples its output per vector and grades it against a latched table.
module truth_table_checker #(
    parameter int N           = 3,
    parameter int STEP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [(1<<N)-1:0]   expected,
    input  logic                y_in,
    output logic [N-1:0]        vec_out,
    output logic                vec_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [(1<<N)-1:0]   capture,
    output logic [N:0]          mismatch_count,
    output logic [N-1:0]        first_fail_idx,
    output logic [1:0]          fsm_state
);

    localparam int NV = 1 << N;
    localparam int HW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [N:0]    LAST_IDX  = (N+1)'(NV - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [N:0]      idx;
    logic [HW-1:0]   hold;
    logic [NV-1:0]   exp_q;
    logic            sample;
    logic            last_vec;
    logic            miss;

    // Handshake: start is a request with no ready; it is taken only when busy=0 (IDLE),
    // anything asserted while busy is dropped, and done pulses once when results are final.
    assign sample    = (state_q == DRIVE) && (hold == LAST_HOLD);
    assign last_vec  = (idx == LAST_IDX);
    assign miss      = (y_in != exp_q[idx[N-1:0]]);
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (sample && last_vec) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out        <= '0;
            vec_valid      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            capture        <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            idx            <= '0;
            hold           <= '0;
            exp_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        exp_q          <= expected;
                        capture        <= '0;
                        mismatch_count <= '0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        hold           <= '0;
                        vec_out        <= '0;
                        vec_valid      <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        capture[idx[N-1:0]] <= y_in;
                        if (miss) begin
                            mismatch_count <= mismatch_count + (N+1)'(1);
                        end
                        // Count still zero means this is the first miss of the run.
                        if (miss && (mismatch_count == '0)) begin
                            first_fail_idx <= idx[N-1:0];
                        end
                        hold <= '0;
                        if (last_vec) begin
                            vec_valid <= 1'b0;
                            vec_out   <= '0;
                            done      <= 1'b1;
                            pass      <= (mismatch_count == '0) && !miss;
                        end else begin
                            idx     <= idx + (N+1)'(1);
                            vec_out <= idx[N-1:0] + N'(1);
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: N=3 table-driven sweeps, start/reset corner cases,
// and the N=1 / N=8 boundary instances.
module tb_truth_table_checker;

    logic clk;
    logic rst;

    // N=3, STEP_CYCLES=2 instance
    logic         start3, y_in3, vec_valid3, busy3, done3, pass3;
    logic [7:0]   expected3, capture3;
    logic [2:0]   vec_out3, first_fail_idx3;
    logic [3:0]   mismatch_count3;
    logic [1:0]   fsm_state3;

    // N=1, STEP_CYCLES=1 instance
    logic         start1, y_in1, vec_valid1, busy1, done1, pass1;
    logic [1:0]   expected1, capture1;
    logic [0:0]   vec_out1, first_fail_idx1;
    logic [1:0]   mismatch_count1;
    logic [1:0]   fsm_state1;

    // N=8, STEP_CYCLES=2 instance
    logic         start8, y_in8, vec_valid8, busy8, done8, pass8;
    logic [255:0] expected8, capture8;
    logic [7:0]   vec_out8, first_fail_idx8;
    logic [8:0]   mismatch_count8;
    logic [1:0]   fsm_state8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] exp_tt;
        bit         hold_start;
        bit         toggle_exp;
        logic [7:0] cap;
        bit         pass;
        logic [3:0] mm;
        logic [2:0] ffi;
    } rec_t;

    rec_t tbl[6];

    truth_table_checker #(.N(3), .STEP_CYCLES(2)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(expected3), .y_in(y_in3),
        .vec_out(vec_out3), .vec_valid(vec_valid3), .busy(busy3), .done(done3), .pass(pass3),
        .capture(capture3), .mismatch_count(mismatch_count3), .first_fail_idx(first_fail_idx3),
        .fsm_state(fsm_state3)
    );

    truth_table_checker #(.N(1), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1), .y_in(y_in1),
        .vec_out(vec_out1), .vec_valid(vec_valid1), .busy(busy1), .done(done1), .pass(pass1),
        .capture(capture1), .mismatch_count(mismatch_count1), .first_fail_idx(first_fail_idx1),
        .fsm_state(fsm_state1)
    );

    truth_table_checker #(.N(8), .STEP_CYCLES(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .expected(expected8), .y_in(y_in8),
        .vec_out(vec_out8), .vec_valid(vec_valid8), .busy(busy8), .done(done8), .pass(pass8),
        .capture(capture8), .mismatch_count(mismatch_count8), .first_fail_idx(first_fail_idx8),
        .fsm_state(fsm_state8)
    );

    // Circuits under test: B|C for N=3, identity for N=1, 8-input parity for N=8
    assign y_in3 = vec_out3[1] | vec_out3[0];
    assign y_in1 = vec_out1[0];
    assign y_in8 = ^vec_out8;

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Driver: one N=3 run starting in the current cycle (called at a negedge = cycle 0)
    task automatic do_run(input rec_t r, input int id);
        logic [2:0] vec_q[$];
        int done_cyc, done_cnt, seq_err, c;
        vec_q = {};
        for (int i = 0; i < 8; i++) begin
            vec_q.push_back(3'(i));
            vec_q.push_back(3'(i));
        end
        done_cyc = -1;
        done_cnt = 0;
        seq_err  = 0;
        expected3 = r.exp_tt;
        start3    = 1'b1;
        for (int cy = 1; cy <= 18; cy++) begin
            @(negedge clk);
            if (!r.hold_start) start3 = 1'b0;
            if (r.toggle_exp && cy == 5)  expected3 = ~r.exp_tt;
            if (r.toggle_exp && cy == 10) expected3 = r.exp_tt;
            if (vec_valid3 === 1'b1) begin
                if (vec_q.size() == 0 || vec_out3 !== vec_q[0]) seq_err++;
                if (vec_q.size() != 0) void'(vec_q.pop_front());
            end else if (vec_out3 !== 3'd0) begin
                seq_err++;
            end
            if (busy3 !== (cy <= 17)) seq_err++;
            if (done3 === 1'b1) begin
                done_cnt++;
                done_cyc = cy;
            end
            if (cy == 17) begin
                chk($sformatf("run%0d_capture", id), capture3, r.cap);
                chk($sformatf("run%0d_pass", id), pass3, r.pass);
                chk($sformatf("run%0d_mismatch_count", id), mismatch_count3, r.mm);
                chk($sformatf("run%0d_first_fail_idx", id), first_fail_idx3, r.ffi);
            end
        end
        chk($sformatf("run%0d_vec_busy_seq_errors", id), seq_err, 0);
        chk($sformatf("run%0d_vectors_left", id), vec_q.size(), 0);
        chk($sformatf("run%0d_done_cycle", id), done_cyc, 17);
        chk($sformatf("run%0d_done_pulses", id), done_cnt, 1);
        if (r.hold_start) begin
            @(negedge clk);
            chk($sformatf("run%0d_restart_busy_c19", id), busy3, 1'b1);
            start3 = 1'b0;
            c = 19;
            while (done3 !== 1'b1 && c < 40) begin
                @(negedge clk);
                c++;
            end
            chk($sformatf("run%0d_restart_done_cycle", id), c, 35);
            chk($sformatf("run%0d_restart_capture", id), capture3, r.cap);
            chk($sformatf("run%0d_restart_pass", id), pass3, r.pass);
            @(negedge clk);
        end
    endtask

    initial begin
        int dc, nd;
        logic [255:0] par_tt;
        logic [7:0]   iv;

        tbl[0] = '{exp_tt: 8'hEE, hold_start: 1'b0, toggle_exp: 1'b0, cap: 8'hEE, pass: 1'b1, mm: 4'd0, ffi: 3'd0};
        tbl[1] = '{exp_tt: 8'hEF, hold_start: 1'b0, toggle_exp: 1'b0, cap: 8'hEE, pass: 1'b0, mm: 4'd1, ffi: 3'd0};
        tbl[2] = '{exp_tt: 8'h11, hold_start: 1'b0, toggle_exp: 1'b0, cap: 8'hEE, pass: 1'b0, mm: 4'd8, ffi: 3'd0};
        tbl[3] = '{exp_tt: 8'hE6, hold_start: 1'b0, toggle_exp: 1'b0, cap: 8'hEE, pass: 1'b0, mm: 4'd1, ffi: 3'd3};
        tbl[4] = '{exp_tt: 8'h2E, hold_start: 1'b0, toggle_exp: 1'b0, cap: 8'hEE, pass: 1'b0, mm: 4'd2, ffi: 3'd6};
        tbl[5] = '{exp_tt: 8'hEE, hold_start: 1'b1, toggle_exp: 1'b1, cap: 8'hEE, pass: 1'b1, mm: 4'd0, ffi: 3'd0};

        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            par_tt[i] = ^iv;
        end

        // Reset held 3 cycles with start high: nothing may launch
        rst = 1'b1;
        start3 = 1'b1; start1 = 1'b1; start8 = 1'b1;
        expected3 = 8'hEE; expected1 = 2'b10; expected8 = par_tt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("reset_dut3_c%0d", k),
                {vec_out3, vec_valid3, busy3, done3, pass3, capture3, mismatch_count3, first_fail_idx3, fsm_state3}, '0);
        end
        chk("reset_dut1", {vec_out1, vec_valid1, busy1, done1, pass1, capture1, mismatch_count1, first_fail_idx1, fsm_state1}, '0);
        chk("reset_dut8", {vec_out8, vec_valid8, busy8, done8, pass8, capture8, mismatch_count8, first_fail_idx8, fsm_state8}, '0);
        rst = 1'b0;
        start3 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_busy3", busy3, 1'b0);

        // Table-driven N=3 sweeps
        for (int t = 0; t < 6; t++) begin
            do_run(tbl[t], t);
        end

        // Mid-run reset in cycle 7
        expected3 = 8'hEE;
        start3 = 1'b1;
        for (int cy = 1; cy <= 7; cy++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (cy == 7) rst = 1'b1;
        end
        @(negedge clk);
        chk("midrun_reset_outputs",
            {vec_out3, vec_valid3, busy3, done3, pass3, capture3, mismatch_count3, first_fail_idx3, fsm_state3}, '0);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done3 === 1'b1) nd++;
        end
        chk("midrun_reset_no_done", nd, 0);
        do_run(tbl[0], 6);

        // Boundary N=1, STEP_CYCLES=1
        expected1 = 2'b10;
        start1 = 1'b1;
        dc = -1;
        for (int cy = 1; cy <= 6; cy++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (cy == 1) chk("n1_vec_c1", {vec_valid1, vec_out1}, 2'b10);
            if (cy == 2) chk("n1_vec_c2", {vec_valid1, vec_out1}, 2'b11);
            if (done1 === 1'b1 && dc < 0) dc = cy;
            if (cy == 3) begin
                chk("n1_capture", capture1, 2'b10);
                chk("n1_pass", pass1, 1'b1);
            end
        end
        chk("n1_done_cycle", dc, 3);

        // Wide case N=8: clean parity table, then two flipped bits
        for (int run = 0; run < 2; run++) begin
            expected8 = par_tt;
            if (run == 1) begin
                expected8[77]  = ~par_tt[77];
                expected8[200] = ~par_tt[200];
            end
            start8 = 1'b1;
            dc = -1;
            for (int cy = 1; cy <= 520 && dc < 0; cy++) begin
                @(negedge clk);
                start8 = 1'b0;
                if (done8 === 1'b1) dc = cy;
            end
            chk($sformatf("n8_run%0d_done_cycle", run), dc, 513);
            chk($sformatf("n8_run%0d_capture", run), capture8, par_tt);
            chk($sformatf("n8_run%0d_pass", run), pass8, (run == 0));
            chk($sformatf("n8_run%0d_mismatch_count", run), mismatch_count8, (run == 0) ? 9'd0 : 9'd2);
            chk($sformatf("n8_run%0d_first_fail_idx", run), first_fail_idx8, (run == 0) ? 8'd0 : 8'd77);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
